// File: rtl/serial_add_pkg.sv
// Shared types and limits for the bit-serial add/subtract controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// Single 1-bit full-adder cell, the only arithmetic in the serial adder.
module fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic cy
);

  assign s  = a ^ b ^ c;
  assign cy = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell time-shared over
// WIDTH clocks, LSB first, with a one-cycle done pulse on completion.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  generate
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
      $error("serial_add_ctrl: WIDTH out of range");
    end
  endgenerate

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, b_sh_reg;
  logic [WIDTH-2:0] res_sh_reg;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg, ovf_reg;
  logic             cell_s, cell_cy;
  logic             last_bit;

  fa u_fa (
    .a  (a_sh_reg[0]),
    .b  (b_sh_reg[0]),
    .c  (carry_reg),
    .s  (cell_s),
    .cy (cell_cy)
  );

  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      res_sh_reg <= '0;
      cnt_reg    <= '0;
      carry_reg  <= 1'b0;
      sum_reg    <= '0;
      cout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b ^ {WIDTH{sub}};
            carry_reg <= sub ? 1'b1 : cin;
            cnt_reg   <= '0;
          end
        end
        RUN: begin
          a_sh_reg   <= a_sh_reg >> 1;
          b_sh_reg   <= b_sh_reg >> 1;
          res_sh_reg <= (WIDTH-1)'({cell_s, res_sh_reg} >> 1);
          carry_reg  <= cell_cy;
          if (last_bit) begin
            // carry_reg still holds the carry into the MSB on this edge
            sum_reg  <= {cell_s, res_sh_reg};
            cout_reg <= cell_cy;
            ovf_reg  <= carry_reg ^ cell_cy;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8: vector table plus
// hand-written hold, mid-run reset and back-to-back sequences.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready, busy, done, cout, ovf;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  typedef struct {
    bit         sub;
    bit         cin;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    bit         cout;
    bit         ovf;
  } vec_t;

  vec_t vecs[10];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .cin   (cin),
    .a     (a),
    .b     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Runs one operation; returns at the sample point just after the done edge.
  task automatic do_op(input vec_t v, input bit hold, input string nm);
    int n;
    int busy_n;
    bit seen_done;
    bit overlap;
    bit sum_moved;
    logic [7:0] prev_sum;
    prev_sum = sum;
    sub = v.sub; cin = v.cin; a = v.a; b = v.b; start = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({nm, "_ready_wait"}, 64'(n < 20), 64'd1);
    @(posedge clk); #1;
    start_cyc = cyc;
    if (!hold) start = 1'b0;
    busy_n = 0; n = 0; seen_done = 0; overlap = 0; sum_moved = 0;
    while (!seen_done && n < 20) begin
      if (busy === 1'b1) busy_n++;
      if (ready === 1'b1 && done === 1'b1) overlap = 1;
      if (sum !== prev_sum) sum_moved = 1;
      if (hold) begin
        a = 8'($urandom); b = 8'($urandom); sub = ~sub; cin = ~cin;
      end
      @(posedge clk); #1; n++;
      if (done === 1'b1) seen_done = 1;
    end
    if (hold) start = 1'b0;
    chk({nm, "_latency"}, 64'(n), 64'(W));
    chk({nm, "_busy_cycles"}, 64'(busy_n), 64'(W));
    chk({nm, "_ready_done_overlap"}, 64'(overlap), 64'd0);
    chk({nm, "_sum_held"}, 64'(sum_moved), 64'd0);
    chk({nm, "_sum"}, 64'(sum), 64'(v.sum));
    chk({nm, "_cout"}, 64'(cout), 64'(v.cout));
    chk({nm, "_ovf"}, 64'(ovf), 64'(v.ovf));
    $display("op %s sub=%0d a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d ovf=%0d lat=%0d",
             nm, v.sub, v.a, v.b, v.cin, sum, cout, ovf, n);
  endtask

  initial begin
    int s0;
    bit any_done;
    vec_t v;

    //            sub  cin  a      b      sum    cout ovf
    vecs[0] = '{1'b0, 1'b0, 8'h3C, 8'h5A, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 8'hAA, 8'h55, 8'h00, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 8'h03, 8'h01, 8'h02, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 8'hC0, 8'hC0, 8'h81, 1'b1, 1'b0};

    #12;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout_ovf", 64'({cout, ovf}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i], 1'b0, $sformatf("vec%0d", i));
    end

    // start held high and operands toggled during RUN
    do_op(vecs[0], 1'b1, "hold");
    @(posedge clk); #1;
    chk("hold_ready_after", 64'(ready), 64'd1);
    @(posedge clk); #1;
    chk("hold_no_second_op", 64'({busy, ready}), 64'b01);

    // reset on the 4th RUN cycle
    sub = 1'b0; cin = 1'b0; a = 8'h77; b = 8'h11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("midrst_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 64'(ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_sum", 64'(sum), 64'd0);
    chk("midrst_cout_ovf", 64'({cout, ovf}), 64'd0);
    any_done = 0;
    repeat (3) begin @(posedge clk); #1; if (done === 1'b1) any_done = 1; end
    @(negedge clk); rst_n = 1'b1;
    repeat (W + 2) begin @(posedge clk); #1; if (done === 1'b1) any_done = 1; end
    chk("midrst_no_done", 64'(any_done), 64'd0);
    $display("op midrst aborted, sum=%02h ready=%0d", sum, ready);
    v = '{1'b0, 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0};
    do_op(v, 1'b0, "post_rst");

    // back-to-back: second start on the first ready cycle after done
    do_op(vecs[4], 1'b0, "b2b_first");
    s0 = start_cyc;
    do_op(vecs[7], 1'b0, "b2b_second");
    chk("b2b_spacing", 64'(start_cyc - s0), 64'(W + 2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
